// File: rtl/icb_pkg.sv
// Shared ICB definitions for the instruction-TCM responder: bus widths,
// responder FSM states and the response payload carried through the FIFO.
package icb_pkg;

  localparam int ICB_AW = 32;
  localparam int ICB_DW = 32;
  localparam int ICB_MW = ICB_DW / 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ISSUE
  } icb_rsp_st_e;

  typedef struct packed {
    logic              err;
    logic [ICB_DW-1:0] rdata;
  } icb_rsp_t;

endpackage

// File: rtl/icb_itcm_rsp_if.sv
// ICB command/response channel between the IFU (master) and the ITCM
// responder (slave).
interface icb_itcm_rsp_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    icb_cmd_valid;
  logic                    icb_cmd_ready;
  logic [ADDR_WIDTH-1:0]   icb_cmd_addr;
  logic                    icb_cmd_read;
  logic [DATA_WIDTH-1:0]   icb_cmd_wdata;
  logic [DATA_WIDTH/8-1:0] icb_cmd_wmask;
  logic                    icb_rsp_valid;
  logic                    icb_rsp_ready;
  logic [DATA_WIDTH-1:0]   icb_rsp_rdata;
  logic                    icb_rsp_err;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    output icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    input  icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

endinterface

// File: rtl/icb_rsp_fifo.sv
// Synchronous response FIFO; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate occupancy counter.
module icb_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/icb_itcm_rsp.sv
// Instruction-side ICB responder for a synchronous-read ITCM with credit-based
// in-order responses. Define ICB_ITCM_RANGE_CHK_EN to reject misaligned or
// out-of-window reads with an error response instead of aliasing.
module icb_itcm_rsp
  import icb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_AW      = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                    RSP_DEPTH   = 4,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  icb_itcm_rsp_if.slave         icb,
  output logic                  mem_en,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int         CW      = $clog2(RSP_DEPTH + 1);
  localparam logic [2:0] LP_WAIT = 3'(WAIT_CYCLES);

  icb_rsp_st_e        r_state;
  logic [2:0]         r_wcnt;
  logic [CW-1:0]      r_cnt;
  logic               r_cmd_err;
  logic [MEM_AW-1:0]  r_cmd_maddr;
  logic               r_ret_valid;
  logic               r_ret_err;

  logic [ADDR_WIDTH:0] w_off;
  logic [MEM_AW-1:0]   w_maddr;
  logic                w_legal;
  logic                w_accept;
  logic                w_rsp_hs;
  icb_rsp_t            w_ret;
  icb_rsp_t            w_head;
  icb_rsp_t            w_out;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_unused;

  // Extra MSB of the offset is the borrow: set when the address is below BASE_ADDR.
  assign w_off   = {1'b0, icb.icb_cmd_addr} - {1'b0, BASE_ADDR};
  assign w_maddr = w_off[MEM_AW+1:2];

`ifdef ICB_ITCM_RANGE_CHK_EN
  assign w_legal = icb.icb_cmd_read
                && (icb.icb_cmd_addr[1:0] == 2'b00)
                && !w_off[ADDR_WIDTH]
                && (w_off[ADDR_WIDTH-1:MEM_AW+2] == '0);
`else
  assign w_legal = icb.icb_cmd_read;
`endif

  assign w_unused = ^{icb.icb_cmd_wdata, icb.icb_cmd_wmask, w_off};

  assign icb.icb_cmd_ready = (r_cnt < CW'(RSP_DEPTH)) && (r_state == IDLE);
  assign w_accept          = icb.icb_cmd_valid && icb.icb_cmd_ready;
  assign w_rsp_hs          = icb.icb_rsp_valid && icb.icb_rsp_ready;

  always_comb begin
    mem_en   = 1'b0;
    mem_addr = '0;
    if (r_state == ISSUE) begin
      mem_en   = !r_cmd_err;
      mem_addr = r_cmd_err ? '0 : r_cmd_maddr;
    end else if ((WAIT_CYCLES == 0) && w_accept && w_legal) begin
      mem_en   = 1'b1;
      mem_addr = w_maddr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_wcnt      <= '0;
      r_cmd_err   <= 1'b0;
      r_cmd_maddr <= '0;
      r_ret_valid <= 1'b0;
      r_ret_err   <= 1'b0;
    end else begin
      r_ret_valid <= 1'b0;
      r_ret_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (WAIT_CYCLES == 0) begin
              r_ret_valid <= 1'b1;
              r_ret_err   <= !w_legal;
            end else begin
              r_cmd_err   <= !w_legal;
              r_cmd_maddr <= w_maddr;
              r_wcnt      <= LP_WAIT;
              r_state     <= WAIT;
            end
          end
        end
        WAIT: begin
          r_wcnt <= r_wcnt - 3'd1;
          if (r_wcnt == 3'd1) r_state <= ISSUE;
        end
        ISSUE: begin
          r_ret_valid <= 1'b1;
          r_ret_err   <= r_cmd_err;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else begin
      case ({w_accept, w_rsp_hs})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Errors share the return slot with SRAM reads so they stay in command order.
  assign w_ret.err   = r_ret_err;
  assign w_ret.rdata = r_ret_err ? '0 : mem_rdata;

  assign w_push = r_ret_valid && !(w_fifo_empty && icb.icb_rsp_ready);
  assign w_pop  = !w_fifo_empty && icb.icb_rsp_ready;

  icb_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH ($bits(icb_rsp_t))
  ) u_fifo (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_push  (w_push),
    .i_wdata (w_ret),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_out = '0;
    if (!w_fifo_empty)    w_out = w_head;
    else if (r_ret_valid) w_out = w_ret;
  end

  assign icb.icb_rsp_valid = !w_fifo_empty || r_ret_valid;
  assign icb.icb_rsp_rdata = w_out.rdata;
  assign icb.icb_rsp_err   = w_out.err;

endmodule

// File: doc/icb_itcm_rsp.md
# icb_itcm_rsp

Instruction-side ICB responder fronting a synchronous-read instruction SRAM. It is the far end of the IFU's `ifu2icache_*` command/response channel: it accepts fetch commands, reads one word per command, and returns responses strictly in order. Credit-based flow control guarantees that no response is ever dropped under `rsp_ready` backpressure. It sits between the IFU (or the icache miss path) and the ITCM macro.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: ICB address width.
- `DATA_WIDTH`, default 32: word width. Must be 32.
- `MEM_AW`, default 12: SRAM word-address width, giving 2^MEM_AW words.
- `BASE_ADDR`, default 32'h0000_0000: byte address of SRAM word 0.
- `RSP_DEPTH`, default 4: maximum outstanding responses. Must be a power of two, ≥2.
- `WAIT_CYCLES`, default 0: extra SRAM access wait states per command, range 0–7.

Ports (one clock; reset is asynchronous, active-low):
- `clk` in 1: clock.
- `rstn` in 1: asynchronous active-low reset.
- `icb_cmd_valid` in 1: command valid.
- `icb_cmd_ready` out 1: command accepted when high together with valid.
- `icb_cmd_addr` in ADDR_WIDTH: byte address.
- `icb_cmd_read` in 1: 1 = read, 0 = write.
- `icb_cmd_wdata` in DATA_WIDTH: ignored.
- `icb_cmd_wmask` in DATA_WIDTH/8: ignored.
- `icb_rsp_valid` out 1: response valid.
- `icb_rsp_ready` in 1: response consumed.
- `icb_rsp_rdata` out DATA_WIDTH: read data.
- `icb_rsp_err` out 1: error response.
- `mem_en` out 1: SRAM read strobe.
- `mem_addr` out MEM_AW: SRAM word address, `(icb_cmd_addr - BASE_ADDR) >> 2`.
- `mem_rdata` in DATA_WIDTH: SRAM data, valid the cycle after `mem_en`.

## Operation
- A command is accepted only on `icb_cmd_valid & icb_cmd_ready`.
- Credit counter `cnt`, range 0..RSP_DEPTH, tracks in-flight plus buffered responses.
  - `cnt` increments on command accept and decrements on response handshake; both in the same cycle leave it unchanged.
  - `icb_cmd_ready = (cnt < RSP_DEPTH) & (state == IDLE)`.
- FSM states:
  - IDLE: on accept, if WAIT_CYCLES == 0, issue `mem_en` in the same cycle and stay in IDLE. Otherwise latch the command, load `wcnt = WAIT_CYCLES`, and go to WAIT.
  - WAIT: decrement `wcnt`. When `wcnt == 1`, go to ISSUE.
  - ISSUE: drive `mem_en` with the latched address for one cycle, then return to IDLE.
- Read, legal address: SRAM is accessed and the response is `{rdata = mem_rdata, err = 0}`.
- Write (`icb_cmd_read = 0`): SRAM is not accessed. The response is `{rdata = 0, err = 1}`. The instruction port is read-only.
- Response path:
  - Returning data is presented combinationally on `icb_rsp_*` when the response FIFO is empty (bypass).
  - Otherwise, or if `icb_rsp_ready` is low, the returning data is pushed into the FIFO.
  - `icb_rsp_valid = !fifo_empty | returning`. When the FIFO is non-empty, the FIFO head is presented.
- FIFO depth is RSP_DEPTH. Credits make overflow impossible; the bench asserts no push when full.
- Responses are returned strictly in command order.
- Error responses travel through the same one-cycle return slot, so ordering is preserved.

## Timing
- Reset values:
  - `icb_cmd_ready` = 1 (cnt = 0, IDLE).
  - `icb_rsp_valid` = 0, `icb_rsp_rdata` = 0, `icb_rsp_err` = 0.
  - `mem_en` = 0, `mem_addr` = 0.
  - FIFO empty, `wcnt` = 0.
- Latency is accept-to-response, with `icb_rsp_ready` held high:
  - 1 cycle when WAIT_CYCLES = 0.
  - 2 + WAIT_CYCLES cycles otherwise.
- Throughput is 1 command per cycle when WAIT_CYCLES = 0 and the consumer does not stall.
- `icb_rsp_rdata` and `icb_rsp_err` hold stable while `icb_rsp_valid & !icb_rsp_ready`.
- FIFO pointers wrap modulo RSP_DEPTH.
- Reset asserted mid-operation discards all in-flight and buffered responses. The first cycle after release is IDLE with `cnt = 0`.

## Configuration
- Macro `ICB_ITCM_RANGE_CHK_EN`, when defined:
  - A read with `addr[1:0] != 0`, or outside `[BASE_ADDR, BASE_ADDR + 4·2^MEM_AW)`, gets response `{rdata = 0, err = 1}`.
  - `mem_en` is not asserted for such a read.
- When not defined:
  - `mem_addr` uses the low MEM_AW bits of the word offset, so the address aliases.
  - `addr[1:0]` is ignored.
  - Only writes produce `err`.

## Structure
- Shared package `icb_pkg`:
  - ICB width constants.
  - State enum `icb_rsp_st_e` {IDLE, WAIT, ISSUE}.
  - Response struct `{err, rdata}`.
- One sub-module, `icb_rsp_fifo`: a synchronous FIFO with DEPTH/WIDTH parameters, full/empty flags and wrap-around pointers, instantiated once.

## Test plan
- Back-to-back reads, WAIT_CYCLES = 0: 8 consecutive reads of addresses 0x0, 0x4, … 0x1C, with SRAM word i = 0xA000_0000 + i. Expect each response exactly 1 cycle after its accept, in order, err = 0, `icb_cmd_ready` constantly 1.
- Backpressure: hold `icb_rsp_ready` = 0 and issue 6 reads. Expect exactly 4 accepts, then `icb_cmd_ready` = 0. Release `icb_rsp_ready`: expect 4 in-order responses from the FIFO, after which accepts resume.
- Write to 0x10: no `mem_en`; response rdata = 0, err = 1, 1 cycle later. A read issued on the following cycle returns the correct data after the error response.
- With `ICB_ITCM_RANGE_CHK_EN` and MEM_AW = 12: read 0x4000 → err = 1, no `mem_en`; read 0x0002 → err = 1. Without the macro, read 0x4000 returns word 0 with err = 0.
- WAIT_CYCLES = 2: a single read is accepted at cycle t, the response is valid at t + 4, and `icb_cmd_ready` is low from t+1 through t+3.
- Reset mid-operation: assert `rstn` low with 3 responses buffered. All outputs take their reset values immediately. After release, a read of 0x0 returns word 0 one cycle after accept.
